// File: rtl/screen_scanout_pkg.sv
// Framebuffer geometry and scanout FSM encoding, shared with the CPU/memory map.
package screen_scanout_pkg;

  localparam int unsigned ADDR_W       = 12;
  localparam logic [ADDR_W-1:0] FB_BASE = 12'h100;
  localparam int unsigned FB_ROWS      = 32;
  localparam int unsigned FB_ROW_BYTES = 8;
  localparam int unsigned PAGES        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Byte address of framebuffer row (page*8 + row), byte column blk.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [1:0] page,
                                                 input logic [2:0] row,
                                                 input logic [2:0] blk);
    return FB_BASE + ADDR_W'({page, row, blk});
  endfunction

endpackage

// File: rtl/screen_scanout_transpose.sv
// 8x8 bit transpose: column byte `col` of the row buffer, bit i taken from row i (MSB = column 0).
module block_transpose8x8 (
  input  logic [7:0][7:0] rows,
  input  logic [2:0]      col,
  output logic [7:0]      col_byte
);

  always_comb begin
    col_byte = '0;
    for (int i = 0; i < 8; i++) begin
      col_byte[i] = rows[i][~col];
    end
  end

endmodule

// File: rtl/screen_scanout.sv
// Reads the 64x32 framebuffer block by block and streams SSD1306-style vertical page bytes.
module screen_scanout
  import screen_scanout_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              busy,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first
);

  state_t          state;
  logic [1:0]      page;
  logic [2:0]      blk;
  logic [2:0]      k;
  logic [2:0]      cap_idx;
  logic            pending;
  logic [7:0][7:0] row_buf;
  logic [7:0][7:0] rows_view;
  logic [2:0]      k_sel;
  logic [7:0]      col_byte;

  // Row buffer as it will look after this cycle's capture, so the first byte can be registered
  // on the same edge that stores row 7.
  always_comb begin
    rows_view = row_buf;
    if (pending) rows_view[cap_idx] = mem_rd_data;
  end

  assign k_sel = (state == ST_EMIT) ? k + 3'd1 : 3'd0;

  block_transpose8x8 u_transpose (
    .rows     (rows_view),
    .col      (k_sel),
    .col_byte (col_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      page        <= '0;
      blk         <= '0;
      k           <= '0;
      cap_idx     <= '0;
      pending     <= 1'b0;
      row_buf     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state       <= ST_READ;
            busy        <= 1'b1;
            page        <= '0;
            blk         <= '0;
            k           <= '0;
            cap_idx     <= '0;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= fb_addr(2'd0, 3'd0, 3'd0);
          end
        end

        ST_READ: begin
          if (mem_rd_req && mem_rd_gnt) begin
            mem_rd_req <= 1'b0;
            pending    <= 1'b1;
          end
          // Data cycle: capture, then either chain the next row read or start emitting.
          if (pending) begin
            row_buf[cap_idx] <= mem_rd_data;
            pending          <= 1'b0;
            cap_idx          <= cap_idx + 3'd1;
            if (cap_idx == 3'd7) begin
              state     <= ST_EMIT;
              k         <= '0;
              out_valid <= 1'b1;
              out_data  <= col_byte;
              out_first <= (page == 2'd0) && (blk == 3'd0);
            end else begin
              mem_rd_req  <= 1'b1;
              mem_rd_addr <= fb_addr(page, cap_idx + 3'd1, blk);
            end
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            out_first <= 1'b0;
            if (k == 3'd7) begin
              out_valid <= 1'b0;
              blk       <= blk + 3'd1;
              if (blk == 3'd7) page <= page + 2'd1;
              if ((blk == 3'd7) && (page == 2'd3)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state       <= ST_READ;
                mem_rd_req  <= 1'b1;
                mem_rd_addr <= fb_addr((blk == 3'd7) ? page + 2'd1 : page, 3'd0, blk + 3'd1);
              end
            end else begin
              k        <= k + 3'd1;
              out_data <= col_byte;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
